// File: rtl/ram2e_pkg.sv
// Shared encodings and slot timing for the RAM2E SDRAM command scheduler.
package ram2e_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_REF  = 3'd4,
    CMD_PALL = 3'd5,
    CMD_MRS  = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_VROW = 3'd1,
    SEL_VCOL = 3'd2,
    SEL_CROW = 3'd3,
    SEL_CCOL = 3'd4,
    SEL_AROW = 3'd5,
    SEL_ACOL = 3'd6,
    SEL_MODE = 3'd7
  } addr_sel_e;

  localparam logic [3:0] PH_IDLE  = 4'd0;
  localparam logic [3:0] PH_FIRST = 4'd1;
  localparam logic [3:0] PH_VACT  = 4'd2;
  localparam logic [3:0] PH_VRD   = 4'd3;
  localparam logic [3:0] PH_VDQ   = 4'd4;
  localparam logic [3:0] PH_VLAT  = 4'd5;
  localparam logic [3:0] PH_REF   = 4'd6;
  localparam logic [3:0] PH_CACT  = 4'd7;
  localparam logic [3:0] PH_CRW   = 4'd8;
  localparam logic [3:0] PH_CDQ   = 4'd9;
  localparam logic [3:0] PH_CLAT  = 4'd10;
  localparam logic [3:0] PH_AACT  = 4'd11;
  localparam logic [3:0] PH_ARW   = 4'd12;
  localparam logic [3:0] PH_ADQ   = 4'd13;
  localparam logic [3:0] PH_AACK  = 4'd14;
  localparam logic [3:0] PH_STALL = 4'd15;

  localparam int CL = 2;

  // Column command for a read/write access; both carry auto-precharge.
  function automatic logic [2:0] rw_cmd(input logic is_write);
    return is_write ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/ram2e_phase_tracker.sv
// PHI1 edge detection, SYNC qualification flags, the saturating Apple-cycle
// phase counter and the refresh timer used while PHI1 is stalled.
module ram2e_phase_tracker
  import ram2e_pkg::*;
#(
  parameter int STALL_REF = 128
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_phi1,
  input  logic       i_sync,
  input  logic       i_run,
  output logic       o_enter,
  output logic [3:0] o_phase_next,
  output logic       o_stall_ref
);

  logic        r_phi1;
  logic        r_phi1_d;
  logic        r_seen_lo;
  logic        r_seen_hi;
  logic [3:0]  r_phase;
  logic [15:0] r_stall_cnt;

  logic        w_rise;
  logic        w_enter;
  logic [3:0]  w_phase_next;
  logic [15:0] w_stall_cnt_next;
  logic        w_stall_ref;

  // Next phase: reload on PHI1 rise, otherwise count up and park at 15.
  always_comb begin
    w_rise  = r_phi1 & ~r_phi1_d;
    w_enter = i_sync & w_rise & r_seen_lo & r_seen_hi;
    if (!i_run && !w_enter) begin
      w_phase_next = PH_IDLE;
    end else if (w_rise) begin
      w_phase_next = PH_FIRST;
    end else if (r_phase == PH_STALL) begin
      w_phase_next = PH_STALL;
    end else begin
      w_phase_next = r_phase + 4'd1;
    end
    w_stall_ref = 1'b0;
    if (w_phase_next == PH_STALL) begin
      if (r_stall_cnt == 16'(STALL_REF - 1)) begin
        w_stall_ref      = 1'b1;
        w_stall_cnt_next = 16'd0;
      end else begin
        w_stall_cnt_next = r_stall_cnt + 16'd1;
      end
    end else begin
      w_stall_cnt_next = 16'd0;
    end
  end

  // Flags only count observations made during the current SYNC visit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phi1      <= 1'b0;
      r_phi1_d    <= 1'b0;
      r_seen_lo   <= 1'b0;
      r_seen_hi   <= 1'b0;
      r_phase     <= PH_IDLE;
      r_stall_cnt <= 16'd0;
    end else begin
      r_phi1      <= i_phi1;
      r_phi1_d    <= r_phi1;
      r_seen_lo   <= i_sync & (r_seen_lo | ~r_phi1);
      r_seen_hi   <= i_sync & (r_seen_hi | r_phi1);
      r_phase     <= w_phase_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

  assign o_enter      = w_enter;
  assign o_phase_next = w_phase_next;
  assign o_stall_ref  = w_stall_ref;

endmodule

// File: rtl/ram2e_sdram_sched.sv
// RAM2E SDRAM scheduler: power-up init sequence, then a fixed per-Apple-cycle
// slot map (video, CPU, refresh, aux) emitted as registered abstract commands.
module ram2e_sdram_sched
  import ram2e_pkg::*;
#(
  parameter int INIT_WAIT = 1432,
  parameter int REF_DIV   = 8,
  parameter int STALL_REF = 128
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic       PHI1,
  input  logic       EN80,
  input  logic       nWE80,
  input  logic       AuxReq,
  input  logic       AuxWE,
  output logic       AuxAck,
  output logic [2:0] Cmd,
  output logic [2:0] AddrSel,
  output logic       DqmEn,
  output logic       VidLatch,
  output logic       CpuLatch,
  output logic       AuxLatch,
  output logic       CKE,
  output logic       Ready
);

  localparam logic [2:0] S_INIT_WAIT = 3'd0;
  localparam logic [2:0] S_INIT_PALL = 3'd1;
  localparam logic [2:0] S_INIT_REF  = 3'd2;
  localparam logic [2:0] S_INIT_MRS  = 3'd3;
  localparam logic [2:0] S_INIT_NOP  = 3'd4;
  localparam logic [2:0] S_SYNC      = 3'd5;
  localparam logic [2:0] S_RUN       = 3'd6;

  localparam logic [15:0] REF_GAP = 16'd8;

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_div;
  logic        r_en80;
  logic        r_we_n;
  logic        r_aux_act;
  logic        r_aux_we;
  logic [2:0]  r_cmd;
  logic [2:0]  r_sel;
  logic        r_dqm;
  logic        r_vid;
  logic        r_cpu;
  logic        r_auxl;
  logic        r_ack;
  logic        r_cke;
  logic        r_ready;

  logic [2:0]  w_state_next;
  logic [15:0] w_cnt_next;
  logic [7:0]  w_div_next;
  logic        w_en80_next;
  logic        w_we_n_next;
  logic        w_aux_act_next;
  logic        w_aux_we_next;
  logic [2:0]  w_cmd;
  logic [2:0]  w_sel;
  logic        w_dqm;
  logic        w_vid;
  logic        w_cpu;
  logic        w_auxl;
  logic        w_ack;
  logic        w_enter;
  logic [3:0]  w_phase_next;
  logic        w_stall_ref;

  ram2e_phase_tracker #(
    .STALL_REF (STALL_REF)
  ) u_phase (
    .i_clk        (C14M),
    .i_rst_n      (nRST),
    .i_phi1       (PHI1),
    .i_sync       (r_state == S_SYNC),
    .i_run        (r_state == S_RUN),
    .o_enter      (w_enter),
    .o_phase_next (w_phase_next),
    .o_stall_ref  (w_stall_ref)
  );

  // Init sequencing and slot decode; outputs are computed for the phase about to be presented.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_div_next     = r_div;
    w_en80_next    = r_en80;
    w_we_n_next    = r_we_n;
    w_aux_act_next = r_aux_act;
    w_aux_we_next  = r_aux_we;
    w_cmd          = CMD_NOP;
    w_sel          = SEL_NONE;
    w_dqm          = 1'b0;
    w_vid          = 1'b0;
    w_cpu          = 1'b0;
    w_auxl         = 1'b0;
    w_ack          = 1'b0;

    case (r_state)
      S_INIT_WAIT: begin
        if (r_cnt == 16'(INIT_WAIT)) begin
          w_state_next = S_INIT_PALL;
          w_cnt_next   = 16'd0;
          w_cmd        = CMD_PALL;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_INIT_PALL: begin
        w_state_next = S_INIT_REF;
        w_cnt_next   = 16'd0;
        w_cmd        = CMD_REF;
      end
      S_INIT_REF: begin
        if (r_cnt == REF_GAP) begin
          w_state_next = S_INIT_MRS;
          w_cnt_next   = 16'd0;
          w_cmd        = CMD_MRS;
          w_sel        = SEL_MODE;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
          if (r_cnt == REF_GAP - 16'd1) begin
            w_cmd = CMD_REF;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
      end
      S_INIT_MRS: begin
        w_state_next = S_INIT_NOP;
        w_cnt_next   = 16'd0;
      end
      S_INIT_NOP: begin
        if (r_cnt == 16'd1) begin
          w_state_next = S_SYNC;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_SYNC: begin
        if (w_enter) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_SYNC;
        end
      end
      S_RUN: begin
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next = S_INIT_WAIT;
        w_cnt_next   = 16'd0;
      end
    endcase

    if (w_state_next == S_RUN) begin
      case (w_phase_next)
        PH_FIRST: begin
          // A reload before ph14 also lands here, silently dropping an unfinished aux access.
          w_aux_act_next = 1'b0;
          if (r_div == 8'(REF_DIV - 1)) begin
            w_div_next = 8'd0;
          end else begin
            w_div_next = r_div + 8'd1;
          end
        end
        PH_VACT: begin
          w_cmd = CMD_ACT;
          w_sel = SEL_VROW;
        end
        PH_VRD: begin
          w_cmd = CMD_RD;
          w_sel = SEL_VCOL;
          w_dqm = 1'b1;
        end
        PH_VDQ: w_dqm = 1'b1;
        PH_VLAT: begin
          w_dqm = 1'b1;
          w_vid = 1'b1;
        end
        PH_REF: begin
          if (r_div == 8'd0) begin
            w_cmd = CMD_REF;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        PH_CACT: begin
          w_en80_next = EN80;
          w_we_n_next = nWE80;
          if (EN80) begin
            w_cmd = CMD_ACT;
            w_sel = SEL_CROW;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        PH_CRW: begin
          if (r_en80) begin
            w_cmd = rw_cmd(~r_we_n);
            w_sel = SEL_CCOL;
            w_dqm = 1'b1;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        PH_CDQ: w_dqm = r_en80;
        PH_CLAT: begin
          w_dqm = r_en80;
          w_cpu = r_en80 & r_we_n;
        end
        PH_AACT: begin
          w_aux_act_next = AuxReq;
          w_aux_we_next  = AuxWE;
          if (AuxReq) begin
            w_cmd = CMD_ACT;
            w_sel = SEL_AROW;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        PH_ARW: begin
          if (r_aux_act) begin
            w_cmd = rw_cmd(r_aux_we);
            w_sel = SEL_ACOL;
            w_dqm = 1'b1;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        PH_ADQ: w_dqm = r_aux_act;
        PH_AACK: begin
          w_dqm          = r_aux_act;
          w_auxl         = r_aux_act & ~r_aux_we;
          w_ack          = r_aux_act;
          w_aux_act_next = 1'b0;
        end
        PH_STALL: begin
          if (w_stall_ref) begin
            w_cmd = CMD_REF;
          end else begin
            w_cmd = CMD_NOP;
          end
        end
        default: w_cmd = CMD_NOP;
      endcase
    end else begin
      w_div_next = r_div;
    end
  end

  // State, slot bookkeeping and every output pin are registered here.
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_INIT_WAIT;
      r_cnt     <= 16'd0;
      r_div     <= 8'd0;
      r_en80    <= 1'b0;
      r_we_n    <= 1'b1;
      r_aux_act <= 1'b0;
      r_aux_we  <= 1'b0;
      r_cmd     <= CMD_NOP;
      r_sel     <= SEL_NONE;
      r_dqm     <= 1'b0;
      r_vid     <= 1'b0;
      r_cpu     <= 1'b0;
      r_auxl    <= 1'b0;
      r_ack     <= 1'b0;
      r_cke     <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_div     <= w_div_next;
      r_en80    <= w_en80_next;
      r_we_n    <= w_we_n_next;
      r_aux_act <= w_aux_act_next;
      r_aux_we  <= w_aux_we_next;
      r_cmd     <= w_cmd;
      r_sel     <= w_sel;
      r_dqm     <= w_dqm;
      r_vid     <= w_vid;
      r_cpu     <= w_cpu;
      r_auxl    <= w_auxl;
      r_ack     <= w_ack;
      r_cke     <= 1'b1;
      r_ready   <= (w_state_next == S_RUN);
    end
  end

  assign Cmd      = r_cmd;
  assign AddrSel  = r_sel;
  assign DqmEn    = r_dqm;
  assign VidLatch = r_vid;
  assign CpuLatch = r_cpu;
  assign AuxLatch = r_auxl;
  assign AuxAck   = r_ack;
  assign CKE      = r_cke;
  assign Ready    = r_ready;

endmodule

// File: tb/tb_ram2e_sdram_sched.sv
// Directed bench for ram2e_sdram_sched: init sequence, per-phase slot map,
// CPU/aux/refresh variants, aux abort, PHI1 stall and asynchronous reset.
module tb_ram2e_sdram_sched;

  logic       C14M = 1'b0;
  logic       nRST = 1'b0;
  logic       PHI1 = 1'b0;
  logic       EN80 = 1'b0;
  logic       nWE80 = 1'b1;
  logic       AuxReq = 1'b0;
  logic       AuxWE = 1'b0;
  logic       AuxAck;
  logic [2:0] Cmd;
  logic [2:0] AddrSel;
  logic       DqmEn;
  logic       VidLatch;
  logic       CpuLatch;
  logic       AuxLatch;
  logic       CKE;
  logic       Ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  wire [10:0] w_obs = {Cmd, AddrSel, DqmEn, VidLatch, CpuLatch, AuxLatch, AuxAck};

  ram2e_sdram_sched dut (
    .C14M     (C14M),
    .nRST     (nRST),
    .PHI1     (PHI1),
    .EN80     (EN80),
    .nWE80    (nWE80),
    .AuxReq   (AuxReq),
    .AuxWE    (AuxWE),
    .AuxAck   (AuxAck),
    .Cmd      (Cmd),
    .AddrSel  (AddrSel),
    .DqmEn    (DqmEn),
    .VidLatch (VidLatch),
    .CpuLatch (CpuLatch),
    .AuxLatch (AuxLatch),
    .CKE      (CKE),
    .Ready    (Ready)
  );

  always #35 C14M = ~C14M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {Cmd, AddrSel, DqmEn, VidLatch, CpuLatch, AuxLatch, AuxAck} for phase p.
  function automatic logic [10:0] slot(input int p, input bit en, input bit wen,
                                       input bit aux, input bit awe, input bit rf);
    logic [2:0] c;
    logic [2:0] s;
    logic d, v, cp, al, ak;
    c = 3'd0; s = 3'd0; d = 1'b0; v = 1'b0; cp = 1'b0; al = 1'b0; ak = 1'b0;
    case (p)
      2:  begin c = 3'd1; s = 3'd1; end
      3:  begin c = 3'd2; s = 3'd2; d = 1'b1; end
      4:  d = 1'b1;
      5:  begin d = 1'b1; v = 1'b1; end
      6:  if (rf) c = 3'd4;
      7:  if (en) begin c = 3'd1; s = 3'd3; end
      8:  if (en) begin c = wen ? 3'd2 : 3'd3; s = 3'd4; d = 1'b1; end
      9:  d = en;
      10: begin d = en; cp = en & wen; end
      11: if (aux) begin c = 3'd1; s = 3'd5; end
      12: if (aux) begin c = awe ? 3'd3 : 3'd2; s = 3'd6; d = 1'b1; end
      13: d = aux;
      14: begin d = aux; al = aux & ~awe; ak = aux; end
      default: ;
    endcase
    return {c, s, d, v, cp, al, ak};
  endfunction

  task automatic do_init();
    int bad;
    PHI1 = 1'b0; EN80 = 1'b0; nWE80 = 1'b1; AuxReq = 1'b0; AuxWE = 1'b0;
    repeat (3) @(posedge C14M);
    #1;
    chk("rst_cke", CKE, 0);
    chk("rst_obs", w_obs, 0);
    chk("rst_ready", Ready, 0);
    @(negedge C14M) nRST = 1'b1;
    bad = 0;
    for (int k = 1; k <= 1432; k++) begin
      @(posedge C14M); #1;
      if (k == 1) chk("cke_first_clk", CKE, 1);
      if (CKE !== 1'b1 || w_obs !== 11'd0) bad++;
    end
    chk("init_wait_nop", bad, 0);
    @(posedge C14M); #1; chk("init_pall", w_obs, {3'd5, 8'd0});
    @(posedge C14M); #1; chk("init_ref1", w_obs, {3'd4, 8'd0});
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge C14M); #1;
      if (w_obs !== 11'd0) bad++;
    end
    chk("init_ref_gap", bad, 0);
    @(posedge C14M); #1; chk("init_ref2", w_obs, {3'd4, 8'd0});
    @(posedge C14M); #1; chk("init_mrs", w_obs, {3'd6, 3'd7, 5'd0});
    @(posedge C14M); #1; chk("init_nop1", w_obs, 0);
    @(posedge C14M); #1; chk("init_nop2", w_obs, 0);
    chk("init_ready", Ready, 0);
  endtask

  // One Apple cycle of len clocks; entered just after the edge that sampled PHI1 high.
  task automatic apple_cycle(input int len, input int h, input bit en, input bit wen,
                             input bit tog, input bit aux, input bit awe);
    bit rf;
    logic [10:0] exp;
    cyc_no++;
    rf = (cyc_no % 8 == 0);
    EN80 = en; nWE80 = wen; AuxReq = aux; AuxWE = awe;
    for (int p = 1; p <= len; p++) begin
      PHI1 = (p == len) || (p < h);
      if (tog && p == 9) nWE80 = ~nWE80;
      @(posedge C14M); #1;
      if (p <= 14) exp = slot(p, en, wen, aux, awe, rf);
      else if ((p - 15) % 128 == 127) exp = {3'd4, 8'd0};
      else exp = 11'd0;
      chk($sformatf("c%0d_ph%0d", cyc_no, p), w_obs, exp);
      if (cyc_no == 1 && p == 1) chk("ready_at_run", Ready, 1);
    end
  endtask

  initial begin
    do_init();
    // SYNC: PHI1 low, one full high/low period, then the qualifying rise.
    repeat (3) @(posedge C14M);
    PHI1 = 1'b1;
    repeat (7) @(posedge C14M);
    PHI1 = 1'b0;
    repeat (7) @(posedge C14M);
    #1;
    chk("ready_pre_sync", Ready, 0);
    PHI1 = 1'b1;
    @(posedge C14M); #1;
    chk("ready_edge_seen", Ready, 0);

    for (int i = 0; i < 8; i++) apple_cycle(14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apple_cycle(14, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apple_cycle(14, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apple_cycle(14, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    apple_cycle(14, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apple_cycle(12, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    apple_cycle(14, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    apple_cycle(420, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    apple_cycle(14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while the video ACT is on the bus.
    @(posedge C14M); #1;
    @(posedge C14M); #1;
    chk("pre_rst_act", w_obs, slot(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    #10 nRST = 1'b0;
    #1;
    chk("async_rst_obs", w_obs, 0);
    chk("async_rst_cke", CKE, 0);
    chk("async_rst_ready", Ready, 0);
    do_init();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram2e_sdram_sched.md
# ram2e_sdram_sched

SDRAM command scheduler for the RAM2E card. It owns the power-up init sequence and the per-Apple-cycle time slots: video read, CPU read/write, periodic refresh, and an auxiliary access port for on-card maintenance logic such as a firmware loader or memory test. It emits abstract commands, address-source selects and latch strobes. A downstream decoder and address mux drive the SDRAM pins.

## Interface
- INIT_WAIT, 1432: C14M clocks of NOP after reset before init (≥100 µs).
- REF_DIV, 8: one auto-refresh every REF_DIV Apple cycles.
- STALL_REF, 128: refresh interval in clocks while PHI1 is stalled.
- C14M  in  1  14.318 MHz clock; all logic on its rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- PHI1  in  1  Apple PHI1, asynchronous to nothing (same source as C14M).
- EN80  in  1  card selected for the CPU access this cycle (delayed nEN80).
- nWE80  in  1  CPU write strobe, active-low.
- AuxReq  in  1  aux access request; held until AuxAck.
- AuxWE  in  1  aux write (1) / read (0); stable while AuxReq is high.
- AuxAck  out  1  one-clock pulse: aux access complete.
- Cmd  out  3  NOP=0, ACT=1, RD=2, WR=3, REF=4, PALL=5, MRS=6 (RD/WR imply auto-precharge).
- AddrSel  out  3  NONE=0, VROW=1, VCOL=2, CROW=3, CCOL=4, AROW=5, ACOL=6, MODE=7.
- DqmEn  out  1  unmask data byte this clock.
- VidLatch, CpuLatch, AuxLatch  out  1 each  capture read data this clock.
- CKE  out  1  SDRAM clock enable.
- Ready  out  1  init done, running slots.

## Operation
- Reset: Cmd=NOP, AddrSel=NONE, DqmEn=0, all latches=0, AuxAck=0, CKE=0, Ready=0, state INIT_WAIT, phase=0, counters=0.
- Init FSM:
  - INIT_WAIT: CKE=1 from the first clock after release; NOP for INIT_WAIT clocks.
  - INIT_PALL: one clock.
  - INIT_REF: two REF commands, 8 clocks apart.
  - INIT_MRS: MRS with AddrSel=MODE.
  - 2 NOP clocks.
  - SYNC.
- SYNC: wait until PHI1 has been seen both low and high, then enter RUN on a PHI1 rising edge. Ready=1 from RUN entry and stays 1 until reset.
- Phase counter (RUN):
  - Loads 1 on each registered PHI1 rising edge.
  - Otherwise increments, saturating at 15.
  - A normal cycle runs phases 1..14; a stretched cycle reaches 15.
- Slot map in RUN; the phase is the value during which Cmd is presented:
  - ph2: ACT/VROW.
  - ph3: RD/VCOL with DqmEn.
  - ph4–5: DqmEn; VidLatch at ph5.
  - ph6: REF if the refresh divider is due, else NOP.
  - ph7: ACT/CROW if EN80, else NOP.
  - ph8: WR if EN80 and ~nWE80, RD if EN80 and nWE80, AddrSel=CCOL, DqmEn.
  - ph9–10: DqmEn if EN80; CpuLatch at ph10 for a read.
  - ph11: ACT/AROW if AuxReq (grant).
  - ph12: RD/WR per AuxWE, ACOL, DqmEn.
  - ph13–14: DqmEn.
  - ph14: AuxLatch (read only) and AuxAck.
  - All other phases: NOP, NONE.
- EN80 and nWE80 are sampled at ph7 and held through ph10. A change after ph7 has no effect.
- Refresh divider increments at ph1 and wraps at REF_DIV; refresh is due at ph6 when the divider equals 0.
- Aux abort: if a PHI1 edge reloads the phase before ph14, the aux access is dropped with no AuxAck. AuxReq stays high and is retried next cycle. A re-issued write is idempotent.
- Stall: while phase saturates at 15, issue REF every STALL_REF clocks, nothing else. Normal slots resume on the next PHI1 edge.
- Reset mid-operation: all outputs go to reset values immediately and the init sequence reruns.

## Timing
- CAS latency 2 is fixed. The latch strobe is 2 clocks after RD, so data is registered by the downstream datapath on that edge.
- At most one command per clock. Every ACT is followed by RD/WR on the next clock, with auto-precharge.
- Minimum spacing between REF and the following ACT is 1 clock (ph6→ph7); tRC ≤ 70 ns is required of the SDRAM part.
- AuxAck latency from AuxReq asserted before ph11: same cycle, at ph14. Worst case is 14 clocks plus one Apple cycle.
- PHI1 is registered once; phase 1 begins the clock after the rising edge is detected.

## Structure
- Shared package ram2e_pkg holds the Cmd and AddrSel encodings, phase constants (PH_VACT=2 … PH_AACK=14) and the CL constant.
- Sub-module ram2e_phase_tracker covers PHI1 registration, seen-low/seen-high flags, the phase counter with saturation, and the stall detect.
- Init FSM, slot decode and refresh divider live in the top module.

## Test plan
- Reset release → CKE=1 next clock; 1432 NOP; PALL; REF; 7 NOP; REF; MRS/MODE; 2 NOP; Ready=1 at the first PHI1 rise after seeing both phases.
- PHI1 period of 14 clocks, EN80=1, nWE80=1 → per cycle ACT ph2, RD ph3, VidLatch ph5, ACT ph7, RD ph8, CpuLatch ph10; REF at ph6 in exactly 1 of 8 cycles.
- EN80=1, nWE80=0 at ph7, nWE80 toggles at ph9 → WR at ph8, no CpuLatch. Then EN80=0 → ph7/ph8 NOP.
- AuxReq=1, AuxWE=0 before ph11 → ACT ph11, RD ph12, AuxLatch and AuxAck at ph14, one clock each. Next cycle with AuxReq dropped → no aux command.
- AuxReq held and a PHI1 edge forced at ph12 → no AuxAck; the access repeats next cycle and is acked at ph14.
- PHI1 held low for 400 clocks → phase holds at 15, REF every 128 clocks, no other commands. PHI1 resumes → phase 1 and the normal slot map.
